// File: rtl/vj_window_feature_eval.sv
// Viola-Jones window evaluator: streams one raster-order window, builds integral and
// squared-integral images, then scores one 3-rectangle Haar feature against a std-dev-scaled threshold.
module vj_window_feature_eval #(
   parameter int WINDOW_SIZE  = 24,
   parameter int RECT1_X      = 0,
   parameter int RECT1_Y      = 0,
   parameter int RECT1_WIDTH  = 6,
   parameter int RECT1_HEIGHT = 6,
   parameter int RECT1_WEIGHT = 1,
   parameter int RECT2_X      = 6,
   parameter int RECT2_Y      = 6,
   parameter int RECT2_WIDTH  = 6,
   parameter int RECT2_HEIGHT = 6,
   parameter int RECT2_WEIGHT = 1,
   parameter int RECT3_X      = 4,
   parameter int RECT3_Y      = 4,
   parameter int RECT3_WIDTH  = 4,
   parameter int RECT3_HEIGHT = 4,
   parameter int RECT3_WEIGHT = -1,
   parameter int FEAT_THRES   = 2,
   parameter int FEAT_ABOVE   = 6,
   parameter int FEAT_BELOW   = -6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pix_valid,
   input  logic [7:0]  pix_data,
   output logic        pix_ready,
   output logic        result_valid,
   output logic [31:0] win_sum,
   output logic [31:0] std_dev,
   output logic [31:0] feature_sum,
   output logic [31:0] feature_accum
);

   localparam int N  = WINDOW_SIZE * WINDOW_SIZE;
   localparam int AW = $clog2(N);
   localparam int CW = $clog2(WINDOW_SIZE + 1);
   localparam logic [5:0] SQRT_LAST = 6'd32;
   localparam logic [5:0] PROD_CNT  = 6'd33;
   localparam logic [5:0] CALC_LAST = 6'd34;

   typedef enum logic {S_LOAD = 1'b0, S_CALC = 1'b1} state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [CW-1:0]     r_x;
   logic [CW-1:0]     r_y;
   logic [31:0]       r_row_sum;
   logic [31:0]       r_sq_row_sum;
   logic [31:0]       r_ii_mem [N];
   logic [31:0]       r_sq_mem [N];
   logic [5:0]        r_calc_cnt;
   logic [63:0]       r_rad;
   logic [35:0]       r_rem;
   logic [31:0]       r_root;
   logic [31:0]       r_feat_sum_c;
   logic [31:0]       r_product;

   logic              w_accept;
   logic              w_last_pix;
   logic [15:0]       w_pix_sq;
   logic [31:0]       w_row_new;
   logic [31:0]       w_sq_row_new;
   logic [31:0]       w_ii_wr;
   logic [31:0]       w_sq_wr;
   logic [AW-1:0]     w_wr_addr;
   logic [31:0]       w_sum;
   logic [31:0]       w_sumsq;
   logic [63:0]       w_var;
   logic [31:0]       w_rect1;
   logic [31:0]       w_rect2;
   logic [31:0]       w_rect3;
   logic signed [31:0] w_feat_sum;
   logic [35:0]       w_rem_sh;
   logic [35:0]       w_trial;
   logic              w_take;

   // Row 0 and column 0 of both images are implicit zeros; stored entry [r-1][c-1] holds II[r][c].
   function automatic logic [31:0] ii_at(input int row, input int col);
      if (row == 0 || col == 0) return 32'd0;
      return r_ii_mem[AW'((row - 1) * WINDOW_SIZE + (col - 1))];
   endfunction

   function automatic logic [31:0] sq_at(input int row, input int col);
      if (row == 0 || col == 0) return 32'd0;
      return r_sq_mem[AW'((row - 1) * WINDOW_SIZE + (col - 1))];
   endfunction

   function automatic logic [31:0] rect_val(input int x, input int y, input int w, input int h);
      return ii_at(y + h, x + w) - ii_at(y, x + w) - ii_at(y + h, x) + ii_at(y, x);
   endfunction

   // ---------------- integral construction ----------------
   assign w_accept     = pix_valid && pix_ready;
   assign w_last_pix   = (r_x == CW'(WINDOW_SIZE - 1)) && (r_y == CW'(WINDOW_SIZE - 1));
   assign w_pix_sq     = pix_data * pix_data;
   assign w_row_new    = ((r_x == '0) ? 32'd0 : r_row_sum) + {24'd0, pix_data};
   assign w_sq_row_new = ((r_x == '0) ? 32'd0 : r_sq_row_sum) + {16'd0, w_pix_sq};
   assign w_ii_wr      = ii_at(int'(r_y), int'(r_x) + 1) + w_row_new;
   assign w_sq_wr      = sq_at(int'(r_y), int'(r_x) + 1) + w_sq_row_new;
   assign w_wr_addr    = AW'(int'(r_y) * WINDOW_SIZE + int'(r_x));

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_ii_mem[w_wr_addr] <= w_ii_wr;
         r_sq_mem[w_wr_addr] <= w_sq_wr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x          <= '0;
         r_y          <= '0;
         r_row_sum    <= '0;
         r_sq_row_sum <= '0;
      end else if (w_accept) begin
         r_row_sum    <= w_row_new;
         r_sq_row_sum <= w_sq_row_new;
         if (r_x == CW'(WINDOW_SIZE - 1)) begin
            r_x <= '0;
            r_y <= w_last_pix ? '0 : r_y + 1'b1;
         end else begin
            r_x <= r_x + 1'b1;
         end
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_LOAD;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      pix_ready    = 1'b0;
      case (r_state)
         S_LOAD: begin
            pix_ready = 1'b1;
            if (w_accept && w_last_pix) w_next_state = S_CALC;
         end
         S_CALC: begin
            if (r_calc_cnt == CALC_LAST) w_next_state = S_LOAD;
         end
         default: w_next_state = S_LOAD;
      endcase
   end

   // ---------------- CALC datapath ----------------
   assign w_sum      = ii_at(WINDOW_SIZE, WINDOW_SIZE);
   assign w_sumsq    = sq_at(WINDOW_SIZE, WINDOW_SIZE);
   assign w_var      = 64'(N) * {32'd0, w_sumsq} - {32'd0, w_sum} * {32'd0, w_sum};
   assign w_rect1    = rect_val(RECT1_X, RECT1_Y, RECT1_WIDTH, RECT1_HEIGHT);
   assign w_rect2    = rect_val(RECT2_X, RECT2_Y, RECT2_WIDTH, RECT2_HEIGHT);
   assign w_rect3    = rect_val(RECT3_X, RECT3_Y, RECT3_WIDTH, RECT3_HEIGHT);
   assign w_feat_sum = RECT1_WEIGHT * $signed(w_rect1) + RECT2_WEIGHT * $signed(w_rect2)
                     + RECT3_WEIGHT * $signed(w_rect3);

   // Restoring square root: two radicand bits enter the remainder per cycle.
   assign w_rem_sh = {r_rem[33:0], r_rad[63:62]};
   assign w_trial  = {2'b00, r_root, 2'b01};
   assign w_take   = (w_rem_sh >= w_trial);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_calc_cnt    <= '0;
         r_rad         <= '0;
         r_rem         <= '0;
         r_root        <= '0;
         r_feat_sum_c  <= '0;
         r_product     <= '0;
         result_valid  <= 1'b0;
         win_sum       <= '0;
         std_dev       <= '0;
         feature_sum   <= '0;
         feature_accum <= '0;
      end else begin
         result_valid <= 1'b0;
         if (r_state == S_CALC) begin
            r_calc_cnt <= r_calc_cnt + 1'b1;
            if (r_calc_cnt == 6'd0) begin
               r_rad        <= w_var;
               r_rem        <= '0;
               r_root       <= '0;
               r_feat_sum_c <= w_feat_sum;
               win_sum      <= win_sum;
            end else if (r_calc_cnt <= SQRT_LAST) begin
               r_rad  <= {r_rad[61:0], 2'b00};
               r_rem  <= w_take ? (w_rem_sh - w_trial) : w_rem_sh;
               r_root <= {r_root[30:0], w_take};
            end else if (r_calc_cnt == PROD_CNT) begin
               r_product <= FEAT_THRES * $signed(r_root);
            end else if (r_calc_cnt == CALC_LAST) begin
               r_calc_cnt    <= '0;
               result_valid  <= 1'b1;
               win_sum       <= w_sum;
               std_dev       <= r_root;
               feature_sum   <= r_feat_sum_c;
               feature_accum <= ($signed(r_feat_sum_c) >= $signed(r_product)) ? FEAT_ABOVE : FEAT_BELOW;
            end
         end else begin
            r_calc_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vj_window_feature_eval.sv
// Self-checking bench for vj_window_feature_eval: directed and random frames scored by a
// pixel-level model (direct rectangle sums, integer sqrt) and compared on every output cycle.
module tb_vj_window_feature_eval;

   localparam int WS = 24;
   localparam int N  = WS * WS;
   localparam int LATENCY = 35;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pix_valid = 1'b0;
   logic [7:0]  pix_data = 8'd0;
   logic        pix_ready;
   logic        result_valid;
   logic [31:0] win_sum, std_dev, feature_sum, feature_accum;

   int checks = 0;
   int errors = 0;
   logic [127:0] exp_q[$];
   int frame_pix [N];

   // model outputs of the most recent frame, kept for pinning against hand-computed values
   int     m_ws, m_std, m_fs, m_acc, m_r1, m_r2, m_r3;
   longint m_var;

   vj_window_feature_eval dut (
      .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_data(pix_data),
      .pix_ready(pix_ready), .result_valid(result_valid), .win_sum(win_sum),
      .std_dev(std_dev), .feature_sum(feature_sum), .feature_accum(feature_accum)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int rect_sum(input int x, input int y, input int w, input int h);
      int s = 0;
      for (int r = y; r < y + h; r++)
         for (int c = x; c < x + w; c++)
            s += frame_pix[r * WS + c];
      return s;
   endfunction

   function automatic longint isqrt(input longint v);
      longint lo = 0, hi = 64'd4294967296, mid;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (mid * mid <= v) lo = mid; else hi = mid;
      end
      return lo;
   endfunction

   task automatic run_model();
      longint s = 0, sq = 0, prod;
      for (int i = 0; i < N; i++) begin
         s  += frame_pix[i];
         sq += longint'(frame_pix[i]) * frame_pix[i];
      end
      m_var = longint'(N) * sq - s * s;
      m_ws  = int'(s);
      m_std = int'(isqrt(m_var));
      m_r1  = rect_sum(0, 0, 6, 6);
      m_r2  = rect_sum(6, 6, 6, 6);
      m_r3  = rect_sum(4, 4, 4, 4);
      m_fs  = m_r1 + m_r2 - m_r3;
      prod  = 2 * longint'(m_std);
      m_acc = (longint'(m_fs) >= prod) ? 6 : -6;
      exp_q.push_back({32'(m_ws), 32'(m_std), 32'(m_fs), 32'(m_acc)});
   endtask

   task automatic fill(input int mode);
      for (int i = 0; i < N; i++) begin
         case (mode)
            0: frame_pix[i] = 2;
            1: frame_pix[i] = (i / WS < 12) ? 1 : 3;
            2: frame_pix[i] = 255;
            default: frame_pix[i] = int'($urandom_range(0, 255));
         endcase
      end
   endtask

   // ---------------- compare process ----------------
   logic [127:0] cur = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         cur = '0;
         chk("reset_outputs", {win_sum, std_dev, feature_sum, feature_accum}, 128'd0);
         chk("reset_result_valid", {127'd0, result_valid}, 128'd0);
      end else if (result_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 128'd1, 128'd0);
         end else begin
            cur = exp_q.pop_front();
            chk("win_sum", {96'd0, win_sum}, {96'd0, cur[127:96]});
            chk("std_dev", {96'd0, std_dev}, {96'd0, cur[95:64]});
            chk("feature_sum", {96'd0, feature_sum}, {96'd0, cur[63:32]});
            chk("feature_accum", {96'd0, feature_accum}, {96'd0, cur[31:0]});
         end
      end else begin
         chk("hold_outputs", {win_sum, std_dev, feature_sum, feature_accum}, cur);
      end
   end

   // ---------------- driver ----------------
   // Called and returns at a negedge; n_pix pixels from frame_pix, optionally with random gaps.
   task automatic send(input int n_pix, input bit gaps, input bit wait_result);
      int idx = 0;
      int cnt;
      while (idx < n_pix) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            pix_valid = 1'b0;
            pix_data  = 8'($urandom_range(0, 255));
         end else begin
            pix_valid = 1'b1;
            pix_data  = 8'(frame_pix[idx]);
            if (pix_ready) idx++;
         end
         @(negedge clk);
      end
      pix_valid = 1'b0;
      if (!wait_result) return;
      cnt = 0;
      while (1) begin
         if (result_valid) begin
            chk("latency", 128'(cnt), 128'(LATENCY));
            chk("pix_ready_on_result", {127'd0, pix_ready}, 128'd1);
            break;
         end
         chk("pix_ready_low_in_calc", {127'd0, pix_ready}, 128'd0);
         if (cnt >= 60) begin
            chk("result_timeout", 128'(cnt), 128'(LATENCY));
            break;
         end
         @(negedge clk);
         cnt++;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("pix_ready_after_reset", {127'd0, pix_ready}, 128'd1);

      // constant 2
      fill(0); run_model();
      chk("pin_c2_win_sum", 128'(m_ws), 128'd1152);
      chk("pin_c2_std", 128'(m_std), 128'd0);
      chk("pin_c2_rects", {32'(m_r1), 32'(m_r2), 32'(m_r3)}, {32'd72, 32'd72, 32'd32});
      chk("pin_c2_fs", 128'(m_fs), 128'd112);
      chk("pin_c2_acc", 128'(m_acc), 128'd6);
      send(N, 1'b0, 1'b1);

      // rows 0-11 = 1, rows 12-23 = 3
      fill(1); run_model();
      chk("pin_rows_var", 128'(m_var), 128'd331776);
      chk("pin_rows_std", 128'(m_std), 128'd576);
      chk("pin_rows_fs", 128'(m_fs), 128'd56);
      chk("pin_rows_acc", {96'd0, 32'(m_acc)}, {96'd0, 32'hFFFF_FFFA});
      send(N, 1'b0, 1'b1);

      // all 255
      fill(2); run_model();
      chk("pin_255_rects", {32'(m_r1), 32'(m_r2), 32'(m_r3)}, {32'd9180, 32'd9180, 32'd4080});
      chk("pin_255_fs", 128'(m_fs), 128'd14280);
      send(N, 1'b0, 1'b1);

      // constant 2 with random valid gaps
      @(negedge clk);
      fill(0); run_model();
      send(N, 1'b1, 1'b1);

      // partial frame aborted by reset, then a full constant-2 frame
      @(negedge clk);
      fill(3);
      send(300, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("pix_ready_after_midreset", {127'd0, pix_ready}, 128'd1);
      fill(0); run_model();
      send(N, 1'b0, 1'b1);

      // back-to-back frames: next first pixel offered in the result_valid cycle
      fill(0); run_model();
      send(N, 1'b0, 1'b1);
      fill(1); run_model();
      send(N, 1'b0, 1'b1);

      // random frames, one with gaps
      for (int f = 0; f < 3; f++) begin
         fill(3); run_model();
         send(N, f == 1, 1'b1);
      end

      repeat (5) @(negedge clk);
      chk("expected_queue_empty", 128'(exp_q.size()), 128'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
